// File: rtl/b_timer_pkg.sv
// rtl/b_timer_pkg.sv - shared state encoding for the b_down_timer FSM
package b_timer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/b_down_timer_if.sv
// rtl/b_down_timer_if.sv - control/status bundle of b_down_timer; `reload` exists only with DOWN_TIMER_AUTORELOAD_EN
interface b_down_timer_if #(
    parameter int N = 4
);
    logic         load;
    logic [N-1:0] load_val;
    logic         start;
    logic         abort;
`ifdef DOWN_TIMER_AUTORELOAD_EN
    logic         reload;
`endif
    logic [N-1:0] q;
    logic         busy;
    logic         tc;

`ifdef DOWN_TIMER_AUTORELOAD_EN
    modport master (output load, load_val, start, abort, reload, input q, busy, tc);
    modport slave  (input load, load_val, start, abort, reload, output q, busy, tc);
`else
    modport master (output load, load_val, start, abort, input q, busy, tc);
    modport slave  (input load, load_val, start, abort, output q, busy, tc);
`endif
endinterface

// File: rtl/b_timer_cnt.sv
// rtl/b_timer_cnt.sv - count register with load/decrement/reload controls plus the reload register
module b_timer_cnt #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cnt_load,
    input  logic         rld_load,
    input  logic         q_reload,
    input  logic         dec,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] q,
    output logic         q_is_one,
    output logic         rld_is_zero
);
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] rld_q, rld_d;

    always_comb begin
        q_d   = q_q;
        rld_d = rld_q;
        if (cnt_load) begin
            q_d   = load_val;
            rld_d = load_val;
        end else if (rld_load) begin
            rld_d = load_val;
        end
        // decrement saturates at zero so the count can never wrap
        if (q_reload) begin
            q_d = rld_q;
        end else if (dec && (q_q != '0)) begin
            q_d = q_q - N'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q   <= '0;
            rld_q <= '0;
        end else begin
            q_q   <= q_d;
            rld_q <= rld_d;
        end
    end

    assign q           = q_q;
    assign q_is_one    = (q_q == N'(1));
    assign rld_is_zero = (rld_q == '0);
endmodule

// File: rtl/b_down_timer.sv
// rtl/b_down_timer.sv - loadable down-timer with start/abort and one-cycle tc; DOWN_TIMER_AUTORELOAD_EN adds periodic mode
module b_down_timer
    import b_timer_pkg::*;
#(
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          reset,
    b_down_timer_if.slave tmr
);
    state_e state_q, state_d;
    logic   cnt_load, rld_load, q_reload, dec;
    logic   q_is_one, rld_is_zero, reload_en;
    logic [N-1:0] q;
    logic [N-1:0] eff_q;

`ifdef DOWN_TIMER_AUTORELOAD_EN
    assign reload_en = tmr.reload;
`else
    assign reload_en = 1'b0;
`endif

    b_timer_cnt #(.N(N)) u_cnt (
        .clk         (clk),
        .reset       (reset),
        .cnt_load    (cnt_load),
        .rld_load    (rld_load),
        .q_reload    (q_reload),
        .dec         (dec),
        .load_val    (tmr.load_val),
        .q           (q),
        .q_is_one    (q_is_one),
        .rld_is_zero (rld_is_zero)
    );

    // a same-cycle load decides whether start sees a zero count
    assign eff_q = tmr.load ? tmr.load_val : q;

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        rld_load = 1'b0;
        q_reload = 1'b0;
        dec      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tmr.abort) begin
                    rld_load = tmr.load;
                end else begin
                    cnt_load = tmr.load;
                    if (tmr.start && (eff_q != '0)) state_d = RUN;
                end
            end
            RUN: begin
                rld_load = tmr.load;
                if (tmr.abort) begin
                    state_d = IDLE;
                end else begin
                    dec = 1'b1;
                    if (q_is_one) state_d = DONE;
                end
            end
            DONE: begin
                rld_load = tmr.load;
                state_d  = IDLE;
                if (!tmr.abort && reload_en && !rld_is_zero) begin
                    q_reload = 1'b1;
                    state_d  = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign tmr.q    = q;
    assign tmr.busy = (state_q != IDLE);
    assign tmr.tc   = (state_q == DONE);
endmodule

// File: tb/tb_b_down_timer.sv
// tb/tb_b_down_timer.sv - directed self-checking bench for b_down_timer (N=4)
module tb_b_down_timer;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    b_down_timer_if #(.N(4)) bus ();

    b_down_timer #(.N(4)) dut (
        .clk   (clk),
        .reset (rst_n),
        .tmr   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.q !== 4'd0) begin $display("FAIL reset_q got=%0d exp=0", bus.q); n_bad++; end
        n_cmp++; if (bus.busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", bus.busy); n_bad++; end
        n_cmp++; if (bus.tc !== 1'b0) begin $display("FAIL reset_tc got=%b exp=0", bus.tc); n_bad++; end
    endtask

    task automatic test_reset_mid_run();
        logic saw_tc;
        bus.load = 1; bus.load_val = 4'd9; bus.start = 1;
        step();
        bus.load = 0; bus.start = 0;
        step(); step();
        n_cmp++; if (bus.q !== 4'd7) begin $display("FAIL midrun_pre_q got=%0d exp=7", bus.q); n_bad++; end
        #2 rst_n = 0;
        #1;
        n_cmp++; if (bus.q !== 4'd0) begin $display("FAIL midrun_rst_q got=%0d exp=0", bus.q); n_bad++; end
        n_cmp++; if (bus.busy !== 1'b0) begin $display("FAIL midrun_rst_busy got=%b exp=0", bus.busy); n_bad++; end
        n_cmp++; if (bus.tc !== 1'b0) begin $display("FAIL midrun_rst_tc got=%b exp=0", bus.tc); n_bad++; end
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        saw_tc = 0;
        repeat (12) begin step(); if (bus.tc !== 1'b0) saw_tc = 1; end
        n_cmp++; if (saw_tc !== 1'b0) begin $display("FAIL midrun_no_tc got=%b exp=0", saw_tc); n_bad++; end
        n_cmp++; if (bus.busy !== 1'b0) begin $display("FAIL midrun_idle_busy got=%b exp=0", bus.busy); n_bad++; end
    endtask

    task automatic test_load_start();
        bus.load = 1; bus.load_val = 4'd5;
        step();
        bus.load = 0;
        n_cmp++; if (bus.q !== 4'd5 || bus.busy !== 1'b0) begin $display("FAIL load_q got=%0d/%b exp=5/0", bus.q, bus.busy); n_bad++; end
        bus.start = 1;
        step();
        bus.start = 0;
        n_cmp++; if (bus.q !== 4'd5 || bus.busy !== 1'b1) begin $display("FAIL start_q got=%0d/%b exp=5/1", bus.q, bus.busy); n_bad++; end
        for (int i = 4; i >= 0; i--) begin
            step();
            n_cmp++;
            if (bus.q !== 4'(i) || bus.tc !== (i == 0)) begin
                $display("FAIL count5_step q=%0d tc=%b exp q=%0d tc=%b", bus.q, bus.tc, i, (i == 0)); n_bad++;
            end
        end
        step();
        n_cmp++; if (bus.q !== 4'd0 || bus.busy !== 1'b0 || bus.tc !== 1'b0) begin $display("FAIL count5_idle got q=%0d busy=%b tc=%b exp 0/0/0", bus.q, bus.busy, bus.tc); n_bad++; end
    endtask

    task automatic test_same_cycle();
        bus.load = 1; bus.load_val = 4'd3; bus.start = 1;
        step();
        bus.load = 0; bus.start = 0;
        n_cmp++; if (bus.q !== 4'd3 || bus.busy !== 1'b1) begin $display("FAIL same_cycle_q got=%0d/%b exp=3/1", bus.q, bus.busy); n_bad++; end
        for (int i = 2; i >= 0; i--) begin
            step();
            n_cmp++;
            if (bus.q !== 4'(i) || bus.tc !== (i == 0)) begin
                $display("FAIL count3_step q=%0d tc=%b exp q=%0d tc=%b", bus.q, bus.tc, i, (i == 0)); n_bad++;
            end
        end
        step();
        bus.start = 1;
        step();
        bus.start = 0;
        n_cmp++; if (bus.busy !== 1'b0 || bus.tc !== 1'b0) begin $display("FAIL start_zero got busy=%b tc=%b exp 0/0", bus.busy, bus.tc); n_bad++; end
        step();
        n_cmp++; if (bus.tc !== 1'b0 || bus.q !== 4'd0) begin $display("FAIL start_zero_after got tc=%b q=%0d exp 0/0", bus.tc, bus.q); n_bad++; end
    endtask

    task automatic test_abort();
        bus.load = 1; bus.load_val = 4'd7;
        step();
        bus.load = 0; bus.start = 1;
        step();
        bus.start = 0;
        step(); step(); step();
        n_cmp++; if (bus.q !== 4'd4) begin $display("FAIL abort_pre_q got=%0d exp=4", bus.q); n_bad++; end
        bus.abort = 1;
        step();
        bus.abort = 0;
        n_cmp++; if (bus.q !== 4'd4 || bus.busy !== 1'b0 || bus.tc !== 1'b0) begin $display("FAIL abort_hold got q=%0d busy=%b tc=%b exp 4/0/0", bus.q, bus.busy, bus.tc); n_bad++; end
        step();
        n_cmp++; if (bus.q !== 4'd4 || bus.busy !== 1'b0) begin $display("FAIL abort_hold2 got q=%0d busy=%b exp 4/0", bus.q, bus.busy); n_bad++; end
        bus.start = 1;
        step();
        bus.start = 0;
        n_cmp++; if (bus.q !== 4'd4 || bus.busy !== 1'b1) begin $display("FAIL resume_q got=%0d/%b exp=4/1", bus.q, bus.busy); n_bad++; end
        for (int i = 3; i >= 0; i--) begin
            step();
            n_cmp++;
            if (bus.q !== 4'(i) || bus.tc !== (i == 0)) begin
                $display("FAIL resume_step q=%0d tc=%b exp q=%0d tc=%b", bus.q, bus.tc, i, (i == 0)); n_bad++;
            end
        end
        step();
        n_cmp++; if (bus.busy !== 1'b0) begin $display("FAIL resume_idle got busy=%b exp 0", bus.busy); n_bad++; end
    endtask

`ifdef DOWN_TIMER_AUTORELOAD_EN
    task automatic test_periodic();
        logic [3:0] exp_q  [11] = '{4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
        logic       exp_tc [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bus.reload = 1;
        bus.load = 1; bus.load_val = 4'd2;
        step();
        bus.load = 0; bus.start = 1;
        step();
        bus.start = 0;
        n_cmp++; if (bus.q !== 4'd2 || bus.busy !== 1'b1) begin $display("FAIL periodic_start got=%0d/%b exp=2/1", bus.q, bus.busy); n_bad++; end
        for (int i = 0; i < 11; i++) begin
            bus.load = (i == 3); bus.load_val = 4'd4;
            bus.reload = (i < 10);
            step();
            n_cmp++;
            if (bus.q !== exp_q[i] || bus.tc !== exp_tc[i]) begin
                $display("FAIL periodic_step%0d q=%0d tc=%b exp q=%0d tc=%b", i, bus.q, bus.tc, exp_q[i], exp_tc[i]); n_bad++;
            end
        end
        bus.load = 0;
        n_cmp++; if (bus.busy !== 1'b0) begin $display("FAIL periodic_idle got busy=%b exp 0", bus.busy); n_bad++; end
    endtask
`endif

    task automatic test_max_count();
        bus.load = 1; bus.load_val = 4'hF;
        step();
        bus.load = 0; bus.start = 1;
        step();
        bus.start = 0;
        n_cmp++; if (bus.q !== 4'd15) begin $display("FAIL max_start got=%0d exp=15", bus.q); n_bad++; end
        for (int i = 14; i >= 0; i--) begin
            step();
            n_cmp++;
            if (bus.q !== 4'(i) || bus.tc !== (i == 0)) begin
                $display("FAIL max_step q=%0d tc=%b exp q=%0d tc=%b", bus.q, bus.tc, i, (i == 0)); n_bad++;
            end
        end
        step();
        n_cmp++; if (bus.q !== 4'd0 || bus.busy !== 1'b0 || bus.tc !== 1'b0) begin $display("FAIL max_no_wrap got q=%0d busy=%b tc=%b exp 0/0/0", bus.q, bus.busy, bus.tc); n_bad++; end
    endtask

    initial begin
        rst_n = 0;
        bus.load = 0; bus.load_val = '0; bus.start = 0; bus.abort = 0;
`ifdef DOWN_TIMER_AUTORELOAD_EN
        bus.reload = 0;
`endif
        @(negedge clk); @(negedge clk);
        test_reset();
        rst_n = 1;
        step();
        test_reset_mid_run();
        test_load_start();
        test_same_cycle();
        test_abort();
`ifdef DOWN_TIMER_AUTORELOAD_EN
        test_periodic();
`endif
        test_max_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/b_down_timer.md
# b_down_timer

Loadable N-bit binary down-counter with start/abort control and a one-cycle terminal-count pulse. It is the consuming counterpart of the free-running up-counter: software or an upstream FSM loads a count, starts it, and receives a `tc` strobe when the count expires. It serves as a timeout/interval generator beside the existing counters in the same clock domain.

## Interface
- `N`, default 4: counter and load-value width.
- `clk`  input  1: sole clock, all state changes on rising edge.
- `reset`  input  1: asynchronous, active-low reset (low = reset asserted).
- `load`  input  1: capture `load_val` into reload register.
- `load_val`  input  N: count value to load.
- `start`  input  1: begin counting from current `q`.
- `abort`  input  1: stop counting immediately, no `tc`.
- `reload`  input  1: periodic mode select, sampled in DONE (present only with `DOWN_TIMER_AUTORELOAD_EN`).
- `q`  output  N: current count, registered.
- `busy`  output  1: high in RUN and DONE.
- `tc`  output  1: terminal-count strobe, high exactly in DONE.

## Operation
- Reset: state IDLE, `q`=0, reload register=0, `busy`=0, `tc`=0.
- States: IDLE, RUN, DONE. `busy`/`tc` are decoded from the state register only (glitch-free, no input-to-output path).
- IDLE:
  - `load`: reload register and `q` take `load_val`.
  - `start` with effective `q`≠0: go to RUN. Effective `q` is `load_val` if `load` is high in the same cycle, else `q`.
  - `start` with effective `q`=0: ignored, stay IDLE, no `tc`.
- RUN:
  - Each edge `q` <= `q`-1.
  - When `q`=1: `q` <= 0 and state <= DONE.
  - `start` is ignored.
  - `load` updates the reload register only; `q` is unaffected and the new value applies at the next reload.
- DONE (one cycle, `q`=0, `tc`=1):
  - Periodic (`reload`=1, macro enabled): `q` <= reload register, state <= RUN. If the reload register is 0, go to IDLE instead.
  - Otherwise: state <= IDLE, `q` holds 0.
- `abort` (any state): next state IDLE, `q` holds its current value.
  - Priority: `abort` > terminal/reload > `start`.
  - `abort` in DONE does not suppress the `tc` already present that cycle; it prevents reload.
- Arithmetic: unsigned, N bits. `q` never wraps below 0. An all-ones load is a valid count of 2^N−1.

## Timing
- `start` sampled at edge k with count L≥1: RUN from edge k with `q`=L. `q`=L−1 after edge k+1. `q`=0 and DONE after edge k+L. `tc` high for the single cycle between edges k+L and k+L+1.
- Start-to-`tc` latency: L cycles. Periodic `tc` spacing: L+1 cycles.
- `load` to `q` visible (IDLE): 1 cycle.
- Async reset assertion forces reset values immediately regardless of `clk`, including mid-RUN. Deassertion is assumed synchronized externally.

## Configuration
- `DOWN_TIMER_AUTORELOAD_EN` defined: `reload` port exists; periodic mode behaves as in DONE above.
- Not defined: `reload` port absent; DONE always returns to IDLE (one-shot only).

## Structure
- Package `b_timer_pkg`: state enum typedef (IDLE, RUN, DONE) and state encoding width constant.
- One sub-module, `b_timer_cnt`:
  - Contains: N-bit count register with load/decrement/hold controls, plus the reload register.
  - Exposes: `q` and a `q_is_one` flag.
  - The FSM lives in `b_down_timer`.

## Test plan
- Reset mid-RUN (N=4, L=9, `reset` low 2 cycles into count) -> `q`=0, `busy`=0, `tc`=0 immediately; no `tc` afterwards.
- Load 5, start next cycle -> `q` sequence 5,4,3,2,1,0. `tc` high exactly 1 cycle, 5 cycles after start edge. Then IDLE, `q`=0.
- Same-cycle `load`=1 `load_val`=3 and `start` -> RUN with `q`=3; `tc` 3 cycles later. `start` with `q`=0 and no `load` -> stays IDLE, no `tc`.
- Load 7, start, `abort` when `q`=4 -> IDLE, `q` holds 4, no `tc`. Later `start` resumes 4→0 with `tc` after 4 cycles.
- Macro on, `reload`=1, load 2, start -> `tc` every 3 cycles. `load` 4 during RUN -> following period becomes 5 cycles. `reload`=0 -> returns to IDLE after next `tc`.
- N=4, load 15, start -> 15 decrements, `tc` after 15 cycles, no wrap to 15 after 0.
